// File: rtl/spi_slave_pkg.sv
// Shared types for the SPI responder: FSM states, SCK mode encodings, underrun fill.
// Pure declarations; no latency or flow control of its own.
package spi_slave_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Encoded as {CPOL, CPHA}
   typedef enum logic [1:0] {
      MODE0 = 2'b00,
      MODE1 = 2'b01,
      MODE2 = 2'b10,
      MODE3 = 2'b11
   } spi_mode_t;

   localparam logic UNDERRUN_FILL = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchroniser plus one edge-detect stage; edges usable on the 3rd CLK after the pin moves.
// No flow control: samples every CLK.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic CLK,
   input  logic PRESET,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   always_ff @(posedge CLK) begin
      if (PRESET) sr <= {3{RST_VAL}};
      else        sr <= {sr[1:0], din};
   end

   assign dout = sr[1];
   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_slave_engine.sv
// SPI responder shift engine with single-entry TX buffer and RX register; oversamples SCK/SS_n/MOSI.
// Pin edges act 3 CLK late; no backpressure: TX underrun sends all-ones, RX overrun drops the word.
module spi_slave_engine
   import spi_slave_pkg::*;
#(
   parameter int data  = 8,
   parameter int cnt_w = 4
) (
   input  logic            CLK,
   input  logic            PRESET,
   input  logic            SPE,
   input  logic            CPOL,
   input  logic            CPHA,
   input  logic            LSBFE,
   input  logic            SCK,
   input  logic            SS_n,
   input  logic            MOSI,
   output logic            MISO,
   output logic            MISO_oe,
   input  logic [data-1:0] tx_wdata,
   input  logic            tx_wr,
   output logic            SPTEF,
   output logic [data-1:0] rx_rdata,
   output logic            SPIF,
   input  logic            rx_rd,
   output logic            OVRF,
   input  logic            ovr_clr,
   output logic            abort,
   output logic            busy
);

   state_t            state, state_nxt;
   spi_mode_t         mode;
   logic              sck_s, sck_rise, sck_fall;
   logic              ss_n_s, ss_rise, ss_fall;
   logic              mosi_s, mosi_rise, mosi_fall;
   logic              unused_sync_outs;
   logic              sample_edge, shift_edge, last_bit;
   logic              load_go, abort_nxt, overrun;
   logic [data-1:0]   tx_buf, tx_sr, rx_sr;
   logic [cnt_w-1:0]  cnt;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
      .CLK(CLK), .PRESET(PRESET), .din(SCK), .dout(sck_s), .rise(sck_rise), .fall(sck_fall));
   spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
      .CLK(CLK), .PRESET(PRESET), .din(SS_n), .dout(ss_n_s), .rise(ss_rise), .fall(ss_fall));
   spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
      .CLK(CLK), .PRESET(PRESET), .din(MOSI), .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

   // SS_n is used as a level so a release during DONE/LOAD is still caught
   assign unused_sync_outs = sck_s | ss_rise | ss_fall | mosi_rise | mosi_fall;

   assign mode = spi_mode_t'({CPOL, CPHA});

   always_comb begin
      sample_edge = 1'b0;
      shift_edge  = 1'b0;
      case (mode)
         MODE0:   begin sample_edge = sck_rise; shift_edge = sck_fall; end
         MODE1:   begin sample_edge = sck_fall; shift_edge = sck_rise; end
         MODE2:   begin sample_edge = sck_fall; shift_edge = sck_rise; end
         MODE3:   begin sample_edge = sck_rise; shift_edge = sck_fall; end
         default: begin sample_edge = 1'b0;     shift_edge = 1'b0;     end
      endcase
   end

   assign last_bit = (cnt == cnt_w'(data - 1));

   always_ff @(posedge CLK) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      abort_nxt = 1'b0;
      if (!SPE) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:  if (!ss_n_s) state_nxt = LOAD;
            LOAD:  begin
               if (ss_n_s) begin
                  state_nxt = IDLE;
                  abort_nxt = 1'b1;
               end else begin
                  state_nxt = SHIFT;
               end
            end
            SHIFT: begin
               if (ss_n_s) begin
                  state_nxt = IDLE;
                  abort_nxt = 1'b1;
               end else if (sample_edge && last_bit) begin
                  state_nxt = DONE;
               end
            end
            DONE:  state_nxt = ss_n_s ? IDLE : LOAD;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign load_go = (state == LOAD) && (state_nxt == SHIFT);
   assign overrun = (state == DONE) && SPIF && !rx_rd;

   assign busy    = (state != IDLE);
   assign MISO_oe = SPE && (state != IDLE);
   assign MISO    = MISO_oe ? (LSBFE ? tx_sr[0] : tx_sr[data-1]) : 1'b0;

   always_ff @(posedge CLK) begin
      if (PRESET) begin
         tx_sr    <= '0;
         rx_sr    <= '0;
         cnt      <= '0;
         tx_buf   <= '0;
         SPTEF    <= 1'b1;
         SPIF     <= 1'b0;
         OVRF     <= 1'b0;
         rx_rdata <= '0;
         abort    <= 1'b0;
      end else begin
         abort <= abort_nxt;

         if (load_go) begin
            tx_sr <= SPTEF ? {data{UNDERRUN_FILL}} : tx_buf;
            cnt   <= '0;
         end else if (state == SHIFT) begin
            if (sample_edge) begin
               rx_sr <= LSBFE ? {mosi_s, rx_sr[data-1:1]} : {rx_sr[data-2:0], mosi_s};
               cnt   <= cnt + 1'b1;
            end
            // cnt==0 marks the edge belonging to the previous word / before the first bit
            if (shift_edge && (cnt != '0))
               tx_sr <= LSBFE ? {1'b0, tx_sr[data-1:1]} : {tx_sr[data-2:0], 1'b0};
         end

         if (tx_wr) begin
            tx_buf <= tx_wdata;
            SPTEF  <= 1'b0;
         end else if (load_go && !SPTEF) begin
            SPTEF  <= 1'b1;
         end

         if ((state == DONE) && (!SPIF || rx_rd)) begin
            rx_rdata <= rx_sr;
            SPIF     <= 1'b1;
         end else if (rx_rd) begin
            SPIF     <= 1'b0;
         end

         if (overrun)      OVRF <= 1'b1;
         else if (ovr_clr) OVRF <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_slave_engine.sv
// Directed bench for spi_slave_engine: table of single-word transfers plus hand-written
// back-to-back/overrun, abort, SPE-off and mid-word reset sequences.
module tb_spi_slave_engine;

   logic       CLK = 1'b0;
   logic       PRESET = 1'b1;
   logic       SPE = 1'b1;
   logic       CPOL = 1'b0;
   logic       CPHA = 1'b0;
   logic       LSBFE = 1'b0;
   logic       SCK = 1'b0;
   logic       SS_n = 1'b1;
   logic       MOSI = 1'b0;
   logic       MISO, MISO_oe;
   logic [7:0] tx_wdata = 8'h00;
   logic       tx_wr = 1'b0;
   logic       SPTEF;
   logic [7:0] rx_rdata;
   logic       SPIF;
   logic       rx_rd = 1'b0;
   logic       OVRF;
   logic       ovr_clr = 1'b0;
   logic       abort;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int abort_cnt = 0;

   spi_slave_engine #(.data(8), .cnt_w(4)) dut (
      .CLK(CLK), .PRESET(PRESET), .SPE(SPE), .CPOL(CPOL), .CPHA(CPHA), .LSBFE(LSBFE),
      .SCK(SCK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe),
      .tx_wdata(tx_wdata), .tx_wr(tx_wr), .SPTEF(SPTEF), .rx_rdata(rx_rdata), .SPIF(SPIF),
      .rx_rd(rx_rd), .OVRF(OVRF), .ovr_clr(ovr_clr), .abort(abort), .busy(busy));

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (abort) abort_cnt <= abort_cnt + 1;

   typedef struct {
      logic       cpol;
      logic       cpha;
      logic       lsbfe;
      logic       wr_tx;
      logic [7:0] tx;
      logic [7:0] mosi;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic write_tx(input logic [7:0] d);
      @(negedge CLK);
      tx_wdata = d;
      tx_wr    = 1'b1;
      @(negedge CLK);
      tx_wr    = 1'b0;
   endtask

   task automatic pulse_rx_rd();
      rx_rd = 1'b1;
      @(negedge CLK);
      rx_rd = 1'b0;
      @(negedge CLK);
   endtask

   // Master side: half SCK period = 4 CLK; MISO captured on the master's sample edge
   task automatic spi_xfer(input logic [7:0] mosi_w, input logic cpol, input logic cpha,
                           input logic lsbfe, input int nbits, output logic [7:0] miso_w);
      miso_w = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         int b;
         b = lsbfe ? i : 7 - i;
         if (!cpha) begin
            MOSI = mosi_w[b];
            cycles(4);
            miso_w[b] = MISO;
            SCK = ~cpol;
            cycles(4);
            SCK = cpol;
         end else begin
            SCK  = ~cpol;
            MOSI = mosi_w[b];
            cycles(4);
            miso_w[b] = MISO;
            SCK = cpol;
            cycles(4);
         end
      end
   endtask

   initial begin
      logic [7:0] mw, mw2;
      int a0;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h6B, 8'hD2, 8'h6B, 8'hD2};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h2C, 8'h71, 8'h2C, 8'h71};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h96, 8'hFF, 8'h96};

      cycles(3);
      PRESET = 1'b0;
      cycles(1);
      chk("rst_miso",    32'(MISO),     32'd0);
      chk("rst_miso_oe", 32'(MISO_oe),  32'd0);
      chk("rst_sptef",   32'(SPTEF),    32'd1);
      chk("rst_spif",    32'(SPIF),     32'd0);
      chk("rst_ovrf",    32'(OVRF),     32'd0);
      chk("rst_rx",      32'(rx_rdata), 32'd0);
      chk("rst_busy",    32'(busy),     32'd0);
      chk("rst_abort",   32'(abort),    32'd0);

      for (int v = 0; v < 5; v++) begin
         CPOL  = vecs[v].cpol;
         CPHA  = vecs[v].cpha;
         LSBFE = vecs[v].lsbfe;
         SCK   = vecs[v].cpol;
         cycles(4);
         if (vecs[v].wr_tx) write_tx(vecs[v].tx);
         SS_n = 1'b0;
         cycles(8);
         chk($sformatf("v%0d_busy", v),        32'(busy),    32'd1);
         chk($sformatf("v%0d_oe", v),          32'(MISO_oe), 32'd1);
         chk($sformatf("v%0d_sptef_load", v),  32'(SPTEF),   32'd1);
         spi_xfer(vecs[v].mosi, vecs[v].cpol, vecs[v].cpha, vecs[v].lsbfe, 8, mw);
         cycles(4);
         chk($sformatf("v%0d_miso", v),  32'(mw),       32'(vecs[v].exp_miso));
         chk($sformatf("v%0d_rx", v),    32'(rx_rdata), 32'(vecs[v].exp_rx));
         chk($sformatf("v%0d_spif", v),  32'(SPIF),     32'd1);
         chk($sformatf("v%0d_ovrf", v),  32'(OVRF),     32'd0);
         SS_n = 1'b1;
         cycles(8);
         chk($sformatf("v%0d_idle_busy", v), 32'(busy),    32'd0);
         chk($sformatf("v%0d_idle_oe", v),   32'(MISO_oe), 32'd0);
         pulse_rx_rd();
         chk($sformatf("v%0d_spif_clr", v),  32'(SPIF),    32'd0);
      end

      // Back-to-back words, second TX written mid-word, second RX word overruns
      CPOL = 1'b0; CPHA = 1'b0; LSBFE = 1'b0; SCK = 1'b0;
      cycles(4);
      write_tx(8'h11);
      SS_n = 1'b0;
      cycles(8);
      write_tx(8'h22);
      chk("b2b_sptef_buffered", 32'(SPTEF), 32'd0);
      spi_xfer(8'h5A, 1'b0, 1'b0, 1'b0, 8, mw);
      spi_xfer(8'hC3, 1'b0, 1'b0, 1'b0, 8, mw2);
      cycles(4);
      chk("b2b_miso_w1", 32'(mw),       32'h11);
      chk("b2b_miso_w2", 32'(mw2),      32'h22);
      chk("b2b_rx_kept", 32'(rx_rdata), 32'h5A);
      chk("b2b_spif",    32'(SPIF),     32'd1);
      chk("b2b_ovrf",    32'(OVRF),     32'd1);
      SS_n = 1'b1;
      cycles(8);
      ovr_clr = 1'b1;
      @(negedge CLK);
      ovr_clr = 1'b0;
      @(negedge CLK);
      chk("ovr_clr", 32'(OVRF), 32'd0);
      chk("ovr_clr_spif_kept", 32'(SPIF), 32'd1);
      pulse_rx_rd();
      chk("b2b_spif_clr", 32'(SPIF), 32'd0);

      // SS_n released after 5 sample edges
      write_tx(8'h55);
      SS_n = 1'b0;
      cycles(8);
      a0 = abort_cnt;
      spi_xfer(8'hFF, 1'b0, 1'b0, 1'b0, 5, mw);
      SS_n = 1'b1;
      cycles(8);
      chk("abort_pulse_cycles", 32'(abort_cnt - a0), 32'd1);
      chk("abort_spif", 32'(SPIF),    32'd0);
      chk("abort_ovrf", 32'(OVRF),    32'd0);
      chk("abort_busy", 32'(busy),    32'd0);
      chk("abort_oe",   32'(MISO_oe), 32'd0);
      chk("abort_sptef", 32'(SPTEF),  32'd1);
      write_tx(8'h3A);
      SS_n = 1'b0;
      cycles(8);
      spi_xfer(8'hE7, 1'b0, 1'b0, 1'b0, 8, mw);
      cycles(4);
      chk("post_abort_miso", 32'(mw),       32'h3A);
      chk("post_abort_rx",   32'(rx_rdata), 32'hE7);
      chk("post_abort_spif", 32'(SPIF),     32'd1);
      SS_n = 1'b1;
      cycles(8);

      // Engine disabled: SS_n low must not start a word
      SPE  = 1'b0;
      SS_n = 1'b0;
      cycles(8);
      chk("spe_off_busy", 32'(busy),    32'd0);
      chk("spe_off_oe",   32'(MISO_oe), 32'd0);
      SS_n = 1'b1;
      cycles(8);
      SPE = 1'b1;
      cycles(2);

      // Reset mid-SHIFT with SPIF=1 and a buffered TX word
      SS_n = 1'b0;
      cycles(8);
      write_tx(8'hC6);
      spi_xfer(8'h0F, 1'b0, 1'b0, 1'b0, 3, mw);
      chk("pre_rst_busy",  32'(busy),  32'd1);
      chk("pre_rst_sptef", 32'(SPTEF), 32'd0);
      a0 = abort_cnt;
      PRESET = 1'b1;
      @(negedge CLK);
      chk("mid_rst_miso",    32'(MISO),     32'd0);
      chk("mid_rst_oe",      32'(MISO_oe),  32'd0);
      chk("mid_rst_sptef",   32'(SPTEF),    32'd1);
      chk("mid_rst_spif",    32'(SPIF),     32'd0);
      chk("mid_rst_ovrf",    32'(OVRF),     32'd0);
      chk("mid_rst_rx",      32'(rx_rdata), 32'd0);
      chk("mid_rst_busy",    32'(busy),     32'd0);
      chk("mid_rst_abort",   32'(abort),    32'd0);
      PRESET = 1'b0;
      @(negedge CLK);
      chk("mid_rst_no_abort", 32'(abort_cnt - a0), 32'd0);
      SS_n = 1'b1;
      cycles(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
